// File: rtl/axis_interpolator.sv
// Two-channel linear interpolator: upsamples an AXI-Stream sample pair by
// 2**INTERP_LOG2 and packs saturated DAC words; repeats the last sample on underrun.
module axis_interpolator #(
    parameter int INTERP_LOG2                       = 2,
    parameter int AXIS_SIGNAL_TDATA_WIDTH           = 32,
    parameter int AXIS_SIGNAL_DATA_WIDTH            = 16,
    parameter int AXIS_SIGNAL_SIGNIFICANT_DATA_WIDTH = 14
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic [AXIS_SIGNAL_DATA_WIDTH-1:0]  S_AXIS_S0_tdata,
    input  logic [AXIS_SIGNAL_DATA_WIDTH-1:0]  S_AXIS_S1_tdata,
    input  logic                               S_AXIS_tvalid,
    output logic                               S_AXIS_tready,
    output logic [AXIS_SIGNAL_TDATA_WIDTH-1:0] M_AXIS_DAC_tdata,
    output logic                               M_AXIS_DAC_tvalid,
    input  logic                               M_AXIS_DAC_tready,
    output logic [15:0]                        underrun_count
);

    localparam int DW = AXIS_SIGNAL_DATA_WIDTH;
    localparam int TW = AXIS_SIGNAL_TDATA_WIDTH;
    localparam int AW = DW + INTERP_LOG2 + 2;
    localparam logic signed [AW-1:0] SMAX =
        AW'(2 ** (AXIS_SIGNAL_SIGNIFICANT_DATA_WIDTH - 1) - 1);
    localparam logic signed [AW-1:0] SMIN = ~SMAX;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t                   state, state_d;
    logic [INTERP_LOG2-1:0]   phase, phase_d;
    logic signed [DW-1:0]     p0, c0, p1, c1;
    logic signed [DW-1:0]     p0_d, c0_d, p1_d, c1_d;
    logic signed [AW-1:0]     acc0, acc1, acc0_d, acc1_d;
    logic [15:0]              urun, urun_d;
    logic                     armed;
    logic                     in_xfer, out_xfer, last_ph;

    function automatic logic signed [AW-1:0] sx(input logic signed [DW-1:0] v);
        return {{(AW-DW){v[DW-1]}}, v};
    endfunction

    function automatic logic [DW-1:0] sat(input logic signed [AW-1:0] v);
        if (v > SMAX) return SMAX[DW-1:0];
        if (v < SMIN) return SMIN[DW-1:0];
        return v[DW-1:0];
    endfunction

    assign last_ph  = &phase;
    assign in_xfer  = S_AXIS_tvalid & S_AXIS_tready;
    assign out_xfer = M_AXIS_DAC_tvalid & M_AXIS_DAC_tready;

    // armed holds tready low until the first edge after reset release
    always_comb begin
        S_AXIS_tready = 1'b0;
        unique case (state)
            IDLE:    S_AXIS_tready = armed;
            HOLD:    S_AXIS_tready = armed;
            RUN:     S_AXIS_tready = armed & last_ph & M_AXIS_DAC_tready;
            default: S_AXIS_tready = 1'b0;
        endcase
    end

    always_comb begin
        M_AXIS_DAC_tvalid = 1'b0;
        M_AXIS_DAC_tdata  = '0;
        unique case (state)
            RUN: begin
                M_AXIS_DAC_tvalid = 1'b1;
                M_AXIS_DAC_tdata  = TW'({sat(acc1 >>> INTERP_LOG2),
                                         sat(acc0 >>> INTERP_LOG2)});
            end
            HOLD: begin
                M_AXIS_DAC_tvalid = 1'b1;
                M_AXIS_DAC_tdata  = TW'({sat(sx(c1)), sat(sx(c0))});
            end
            default: begin
                M_AXIS_DAC_tvalid = 1'b0;
                M_AXIS_DAC_tdata  = '0;
            end
        endcase
    end

    always_comb begin
        state_d = state;
        phase_d = phase;
        p0_d    = p0;
        c0_d    = c0;
        p1_d    = p1;
        c1_d    = c1;
        acc0_d  = acc0;
        acc1_d  = acc1;
        urun_d  = urun;
        unique case (state)
            IDLE: begin
                if (in_xfer) begin
                    p0_d    = S_AXIS_S0_tdata;
                    c0_d    = S_AXIS_S0_tdata;
                    p1_d    = S_AXIS_S1_tdata;
                    c1_d    = S_AXIS_S1_tdata;
                    acc0_d  = sx(S_AXIS_S0_tdata) <<< INTERP_LOG2;
                    acc1_d  = sx(S_AXIS_S1_tdata) <<< INTERP_LOG2;
                    phase_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (out_xfer && !last_ph) begin
                    phase_d = phase + INTERP_LOG2'(1);
                    acc0_d  = acc0 + (sx(c0) - sx(p0));
                    acc1_d  = acc1 + (sx(c1) - sx(p1));
                end else if (out_xfer && !in_xfer) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_xfer && urun != 16'hFFFF) urun_d = urun + 16'd1;
                if (in_xfer) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
        // a new segment always ramps away from the previous current sample
        if (in_xfer && state != IDLE) begin
            p0_d    = c0;
            c0_d    = S_AXIS_S0_tdata;
            p1_d    = c1;
            c1_d    = S_AXIS_S1_tdata;
            acc0_d  = sx(c0) <<< INTERP_LOG2;
            acc1_d  = sx(c1) <<< INTERP_LOG2;
            phase_d = '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            phase <= '0;
            p0    <= '0;
            c0    <= '0;
            p1    <= '0;
            c1    <= '0;
            acc0  <= '0;
            acc1  <= '0;
            urun  <= '0;
            armed <= 1'b0;
        end else begin
            state <= state_d;
            phase <= phase_d;
            p0    <= p0_d;
            c0    <= c0_d;
            p1    <= p1_d;
            c1    <= c1_d;
            acc0  <= acc0_d;
            acc1  <= acc1_d;
            urun  <= urun_d;
            armed <= 1'b1;
        end
    end

    assign underrun_count = urun;

endmodule

// File: tb/tb_axis_interpolator.sv
// Scoreboard bench for axis_interpolator: a reference model pushes expected
// DAC words as samples are accepted; a negedge monitor pops and compares.
module tb_axis_interpolator;

    localparam int N = 4;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [15:0] s0, s1;
    logic        s_valid, s_ready;
    logic [31:0] m_data;
    logic        m_valid, m_ready;
    logic [15:0] urun;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        hold;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   mp0, mc0, mp1, mc1;
    bit   midle = 1'b1;
    bit   streaming = 1'b0;

    always #5 aclk = ~aclk;

    axis_interpolator dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .S_AXIS_S0_tdata   (s0),
        .S_AXIS_S1_tdata   (s1),
        .S_AXIS_tvalid     (s_valid),
        .S_AXIS_tready     (s_ready),
        .M_AXIS_DAC_tdata  (m_data),
        .M_AXIS_DAC_tvalid (m_valid),
        .M_AXIS_DAC_tready (m_ready),
        .underrun_count    (urun)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int fdiv(input int num, input int d);
        int r;
        r = num / d;
        if ((num % d != 0) && (num < 0)) r = r - 1;
        return r;
    endfunction

    function automatic logic [15:0] sat16(input int v);
        int t;
        t = v;
        if (t > 8191) t = 8191;
        else if (t < -8192) t = -8192;
        return t[15:0];
    endfunction

    function automatic logic [31:0] ref_word(input int k);
        int a, b;
        a = fdiv(mp0 * N + k * (mc0 - mp0), N);
        b = fdiv(mp1 * N + k * (mc1 - mp1), N);
        return {sat16(b), sat16(a)};
    endfunction

    always @(negedge aclk) begin : monitor
        exp_t e;
        if (aresetn === 1'b1) begin
            if (streaming && q.size() > 0)
                check("tvalid", {31'b0, m_valid}, 32'd1);
            if (m_valid === 1'b1 && q.size() > 0)
                check("s_tready", {31'b0, s_ready},
                      {31'b0, q[0].hold | (q[0].last & m_ready)});
            if (m_valid === 1'b1 && m_ready) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL extra_word: got %h expected none", m_data);
                end else begin
                    e = q.pop_front();
                    check("tdata", m_data, e.data);
                end
            end
        end
    end

    task automatic send(input int v0, input int v1);
        bit ok;
        exp_t e;
        ok = 1'b0;
        s0 = v0[15:0];
        s1 = v1[15:0];
        s_valid = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge aclk);
            if (s_ready === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            check("send_timeout", {31'b0, s_ready}, 32'd1);
            s_valid = 1'b0;
            return;
        end
        mp0 = midle ? v0 : mc0;
        mp1 = midle ? v1 : mc1;
        mc0 = v0;
        mc1 = v1;
        midle = 1'b0;
        for (int k = 0; k < N; k++) begin
            e.data = ref_word(k);
            e.last = (k == N - 1);
            e.hold = 1'b0;
            q.push_back(e);
        end
        @(posedge aclk);
        #1;
        s_valid = 1'b0;
        streaming = 1'b1;
    endtask

    task automatic stall(input int n);
        exp_t e;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < n; i++) begin
            e.data = {sat16(mc1), sat16(mc0)};
            e.last = 1'b0;
            e.hold = 1'b1;
            q.push_back(e);
        end
        for (int t = 0; t < 200 && !ok; t++) begin
            @(posedge aclk);
            #1;
            if (q.size() <= 1) ok = 1'b1;
        end
        if (!ok) check("stall_timeout", 32'(q.size()), 32'd1);
    endtask

    task automatic wait_left(input int n);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(posedge aclk);
            #1;
            if (q.size() == n) ok = 1'b1;
        end
        if (!ok) check("wait_timeout", 32'(q.size()), 32'(n));
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && q.size() != 0; t++) begin
            @(posedge aclk);
            #1;
        end
        m_ready = 1'b0;
        check("drain", 32'(q.size()), 32'd0);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_tvalid"}, {31'b0, m_valid}, 32'd0);
        check({tag, "_tdata"}, m_data, 32'd0);
        check({tag, "_s_tready"}, {31'b0, s_ready}, 32'd0);
        check({tag, "_underrun"}, {16'b0, urun}, 32'd0);
    endtask

    task automatic release_reset();
        @(negedge aclk);
        #2;
        aresetn = 1'b1;
        #1;
        check("rel_tready_lo", {31'b0, s_ready}, 32'd0);
        @(posedge aclk);
        #1;
        check("rel_tready_hi", {31'b0, s_ready}, 32'd1);
    endtask

    initial begin
        aresetn = 1'b0;
        s_valid = 1'b0;
        s0 = '0;
        s1 = '0;
        m_ready = 1'b1;
        #12;
        reset_checks("por");
        release_reset();

        send(400, -400);
        send(800, -800);
        stall(6);
        send(1200, 1200);
        check("underrun_6", {16'b0, urun}, 32'd6);

        wait_left(2);
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("bp_tdata", m_data, q[0].data);
            check("bp_s_tready", {31'b0, s_ready}, 32'd0);
            check("bp_tvalid", {31'b0, m_valid}, 32'd1);
        end
        @(posedge aclk);
        #1;
        m_ready = 1'b1;

        stall(2);
        send(-100, 5);
        send(-103, 5);
        drain();
        check("underrun_8", {16'b0, urun}, 32'd8);

        #3;
        aresetn = 1'b0;
        q.delete();
        streaming = 1'b0;
        midle = 1'b1;
        #1;
        reset_checks("rst1");
        m_ready = 1'b1;
        release_reset();

        send(32767, -32768);
        check("sat_pack", m_data, 32'hE0001FFF);
        send(1000, 2000);
        wait_left(2);
        #2;
        aresetn = 1'b0;
        q.delete();
        streaming = 1'b0;
        midle = 1'b1;
        s_valid = 1'b0;
        #1;
        reset_checks("mid_run");
        repeat (2) @(posedge aclk);
        release_reset();

        send(300, -300);
        drain();
        check("underrun_0", {16'b0, urun}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/axis_interpolator.md
AXIS_INTERPOLATOR -- requirements
Module: axis_interpolator

Interface
REQ-001 Parameter INTERP_LOG2, default 2, meaning: log2 of the interpolation factor N (N = 4 by default); legal range 1..4.
REQ-002 Parameter AXIS_SIGNAL_TDATA_WIDTH, default 32, meaning: packed DAC word width.
REQ-003 Parameter AXIS_SIGNAL_DATA_WIDTH, default 16, meaning: per-channel input sample width.
REQ-004 Parameter AXIS_SIGNAL_SIGNIFICANT_DATA_WIDTH, default 14, meaning: DAC resolution per channel.
REQ-005 aclk  input  1  sole clock; all logic on rising edge.
REQ-006 aresetn  input  1  reset, asynchronous assert, active-low.
REQ-007 S_AXIS_S0_tdata  input  16  channel 0 sample, signed two's complement.
REQ-008 S_AXIS_S1_tdata  input  16  channel 1 sample, signed two's complement.
REQ-009 S_AXIS_tvalid  input  1  both channel samples valid.
REQ-010 S_AXIS_tready  output  1  block accepts a sample pair.
REQ-011 M_AXIS_DAC_tdata  output  32  packed DAC word: [15:0] = ch0, [31:16] = ch1, each a 14-bit value sign-extended to 16.
REQ-012 M_AXIS_DAC_tvalid  output  1  DAC word valid.
REQ-013 M_AXIS_DAC_tready  input  1  downstream accepts the word.
REQ-014 underrun_count  output  16  saturating count of HOLD words emitted.

Function
REQ-015 An input transfer SHALL occur when S_AXIS_tvalid and S_AXIS_tready are both high on a rising edge; an output transfer SHALL occur when M_AXIS_DAC_tvalid and M_AXIS_DAC_tready are both high.
REQ-016 States SHALL be IDLE (no sample yet, tvalid 0), RUN (emitting phases 0..N-1), and HOLD (underrun, repeating the last sample).
REQ-017 Per channel, the block SHALL hold registers p (previous) and c (current); on an input transfer, p <= c and c <= new sample, except from IDLE, where p <= new sample and c <= new sample.
REQ-018 In RUN, phase k (0..N-1) SHALL output floor((p*N + k*(c-p)) / N), computed with an accumulator that starts at p<<INTERP_LOG2, adds the 17-bit delta (c-p) per phase, and is arithmetically shifted right by INTERP_LOG2; results SHALL be exact, with no intermediate overflow.
REQ-019 Each channel result SHALL saturate to [-8192, 8191] before packing.
REQ-020 The phase counter SHALL advance only on an output transfer; M_AXIS_DAC_tdata and M_AXIS_DAC_tvalid SHALL hold stable while tvalid=1 and tready=0.
REQ-021 S_AXIS_tready SHALL be 1 in IDLE and HOLD, and in RUN only when phase = N-1 and M_AXIS_DAC_tready = 1 (seamless chaining); it SHALL be 0 otherwise.
REQ-022 An input transfer coincident with the phase N-1 output transfer SHALL start phase 0 of the new segment on the next cycle, with no bubble.
REQ-023 If phase N-1 is transferred without an input transfer, the state SHALL become HOLD, which emits sat(c) each word and increments underrun_count per HOLD output transfer, saturating at 16'hFFFF.
REQ-024 An input transfer in HOLD SHALL enter RUN at phase 0 with p = old c, i.e. the ramp starts from the held value.
REQ-025 Latency: the first output word SHALL be valid on the cycle after the input transfer (IDLE->RUN, HOLD->RUN).
REQ-026 IDLE SHALL transition only to RUN; RUN and HOLD never return to IDLE except by reset.

Reset
REQ-027 While aresetn=0: state IDLE, p=c=0, phase 0, M_AXIS_DAC_tdata=0, M_AXIS_DAC_tvalid=0, S_AXIS_tready=0, underrun_count=0.
REQ-028 S_AXIS_tready SHALL rise on the first rising edge after aresetn deasserts.
REQ-029 Reset asserted mid-segment SHALL discard any partial segment immediately and asynchronously.

Verification
REQ-030 Ramp, tready=1: ch0 inputs 400 then 800 back-to-back -> ch0 outputs 400,400,400,400,400,500,600,700; no gaps; tready high only on the phase-3 cycles.
REQ-031 Negative floor: p=-100, c=-103 -> ch0 outputs -100,-101,-102,-103.
REQ-032 Saturation and packing: ch0=16'h7FFF, ch1=16'h8000 in IDLE -> tdata=32'hE0001FFF for 4 words.
REQ-033 Backpressure: hold M_AXIS_DAC_tready=0 for 5 cycles at phase 2 -> tdata constant, phase does not advance, S_AXIS_tready=0 throughout.
REQ-034 Underrun: after the segment 400->800, stall input 6 words -> 800 repeated 6 times, underrun_count=6; next input 1200 -> outputs 800,900,1000,1100.
REQ-035 Reset mid-RUN at phase 2 -> tvalid=0 and tdata=0 immediately; the first sample after release is treated as from IDLE (4 flat words).
